// File: rtl/pulse_sync_mc.sv
// Multi-channel toggle-event receiver: per-channel synchroniser, edge detect and
// saturating pending counter, merged round-robin onto one valid/ready port.
// Optional overflow flags when PULSE_SYNC_OVF_EN is defined.
module pulse_sync_mc #(
  parameter int NCH         = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 3,
  localparam int CH_W       = $clog2(NCH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NCH-1:0]  tgl_in,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic [CH_W-1:0] evt_ch,
  output logic [NCH-1:0]  pend
`ifdef PULSE_SYNC_OVF_EN
  ,
  input  logic [NCH-1:0]  ovf_clr,
  output logic [NCH-1:0]  ovf
`endif
);

  localparam int              PRIME_W = $clog2(SYNC_STAGES + 2);
  localparam logic [PRIME_W-1:0] PRIME_N = PRIME_W'(SYNC_STAGES + 1);
  localparam logic [CNT_W-1:0]   CNT_MAX = '1;

  logic [NCH-1:0]     w_edge;
  logic [NCH-1:0]     w_nz;
  logic [NCH-1:0]     w_grant;
  logic [PRIME_W-1:0] r_prime;
  logic               w_priming;
  logic               w_free;
  logic               w_gnt_any;
  logic [CH_W-1:0]    w_gnt_idx;
  logic [CH_W-1:0]    r_ptr;
  logic               r_evt_valid;
  logic [CH_W-1:0]    r_evt_ch;

  // Edges are masked until the synchronisers hold post-reset input levels.
  assign w_priming = (r_prime != PRIME_N);
  assign w_free    = !r_evt_valid || evt_ready;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      logic [SYNC_STAGES-1:0] r_sync;
      logic                   r_hist;
      logic [CNT_W-1:0]       r_cnt;
      logic [CNT_W-1:0]       w_cnt_next;
      logic                   r_pend;
      logic                   w_s;

      assign w_s         = r_sync[SYNC_STAGES-1];
      assign w_edge[gi]  = (w_s ^ r_hist) & ~w_priming;
      assign w_nz[gi]    = (r_cnt != '0);
      assign w_grant[gi] = w_gnt_any && (w_gnt_idx == CH_W'(gi));
      assign pend[gi]    = r_pend;

      // Simultaneous increment and grant cancel, so a full counter loses nothing.
      always_comb begin
        w_cnt_next = r_cnt;
        if (w_edge[gi] && !w_grant[gi]) begin
          if (r_cnt != CNT_MAX)
            w_cnt_next = r_cnt + CNT_W'(1);
        end else if (!w_edge[gi] && w_grant[gi]) begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_sync <= '0;
          r_hist <= 1'b0;
          r_cnt  <= '0;
          r_pend <= 1'b0;
        end else begin
          r_sync <= {r_sync[SYNC_STAGES-2:0], tgl_in[gi]};
          r_hist <= w_s;
          r_cnt  <= w_cnt_next;
          r_pend <= (w_cnt_next != '0);
        end
      end

`ifdef PULSE_SYNC_OVF_EN
      logic r_ovf;
      logic w_drop;
      assign w_drop  = w_edge[gi] && !w_grant[gi] && (r_cnt == CNT_MAX);
      assign ovf[gi] = r_ovf;

      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          r_ovf <= 1'b0;
        else if (w_drop)
          r_ovf <= 1'b1;
        else if (ovf_clr[gi])
          r_ovf <= 1'b0;
      end
`endif
    end
  endgenerate

  // Round-robin search from r_ptr; scanning backwards lets the nearest hit win.
  always_comb begin
    int w_idx;
    w_gnt_any = 1'b0;
    w_gnt_idx = r_ptr;
    w_idx     = 0;
    if (w_free) begin
      for (int k = NCH - 1; k >= 0; k--) begin
        w_idx = (int'(r_ptr) + k) % NCH;
        if (w_nz[w_idx]) begin
          w_gnt_any = 1'b1;
          w_gnt_idx = CH_W'(w_idx);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prime     <= '0;
      r_ptr       <= '0;
      r_evt_valid <= 1'b0;
      r_evt_ch    <= '0;
    end else begin
      if (w_priming)
        r_prime <= r_prime + PRIME_W'(1);
      if (w_free) begin
        if (w_gnt_any) begin
          r_evt_valid <= 1'b1;
          r_evt_ch    <= w_gnt_idx;
          r_ptr       <= (w_gnt_idx == CH_W'(NCH - 1)) ? '0 : w_gnt_idx + CH_W'(1);
        end else begin
          r_evt_valid <= 1'b0;
        end
      end
    end
  end

  assign evt_valid = r_evt_valid;
  assign evt_ch    = r_evt_ch;

endmodule

// File: doc/pulse_sync_mc.md
Name: pulse_sync_mc

Overview:
- Multi-channel event receiver in the destination clock domain; successor to the single-channel two-domain pulse handshake.
- Each channel takes an asynchronous toggle from a foreign domain: one level change = one event.
- Per channel: parametrised-depth synchroniser, edge detection and a saturating pending-event counter, so bursts are not lost.
- Pending events from all channels are merged round-robin onto one valid/ready event port carrying the channel index.

Parameters:
- NCH, 4, number of channels (>=2).
- SYNC_STAGES, 2, synchroniser flop depth per channel (>=2).
- CNT_W, 3, pending-counter width per channel; max 2^CNT_W-1 events buffered.
- CH_W (localparam), clog2(NCH), width of evt_ch.

Ports:
- clk  in  1  destination clock; all flops on posedge.
- rst  in  1  asynchronous active-high reset.
- tgl_in  in  NCH  per-channel asynchronous toggle; each level change is one event.
- evt_valid  out  1  event available on evt_ch.
- evt_ready  in  1  consumer accepts the event when high with evt_valid.
- evt_ch  out  CH_W  channel index of the presented event.
- pend  out  NCH  per-channel "counter non-zero" status, registered.

Behaviour:
- Reset values, async assert, sync deassert by clk: evt_valid=0, evt_ch=0, pend=0. Also cleared: all sync/history flops, counters, RR pointer (=0), prime counter.
- Sync: tgl_in[i] -> SYNC_STAGES flops -> s[i]; history flop h[i]<=s[i]; edge e[i]=s[i]^h[i].
- Latency: a toggle sampled at edge E0 increments cnt[i] at edge E0+SYNC_STAGES. It can appear on evt_valid at E0+SYNC_STAGES+1 if the output slot is free.
- Priming: for SYNC_STAGES+1 cycles after reset release, e[] is forced 0 while h[] tracks s[]. A toggle input already high at reset therefore creates no event.
- Counter: inc=e[i], dec=grant[i].
  - inc only: +1; at max the event is dropped and cnt holds.
  - dec only: -1.
  - Both: unchanged (max stays max; nothing dropped).
- Output slot is one register.
  - Slot free = !evt_valid | evt_ready.
  - When free and any cnt>0: grant one channel, load evt_ch, set evt_valid=1, decrement that cnt, all at the same edge.
  - When free and no cnt>0: evt_valid<=0.
- Handshake: while evt_valid=1 and evt_ready=0, evt_valid and evt_ch hold stable. Back-to-back: with evt_ready tied high, one event per cycle.
- Arbitration: round-robin. Search starts at ptr; after a grant to i, ptr<=(i+1) mod NCH; ptr unchanged without a grant.
- pend[i] is registered (cnt[i]!=0) after the update, i.e. it reflects the counter state following each edge.
- Reset mid-operation: pending and presented events are discarded; priming restarts.
- Toggle faster than every 2 clk cycles per channel is unsupported (edges may merge). The source guarantees this.

Optional Feature:
- Macro: PULSE_SYNC_OVF_EN
- Defined: adds ports ovf_clr in NCH and ovf out NCH.
  - ovf[i] is a sticky flag, set the cycle after an event is dropped at saturation.
  - ovf_clr[i] clears it; set wins over a simultaneous clear.
  - Reset value 0.
- Undefined: no such ports; drops are silent. All other behaviour is identical.

Test Plan:
- Reset with tgl_in=4'b1010 held, release, wait 10 cycles -> evt_valid stays 0, pend=0.
- Toggle tgl_in[2] once, evt_ready=1 -> after SYNC_STAGES+1 cycles (3 at default) evt_valid=1 for exactly 1 cycle, evt_ch=2.
- Toggle all four channels in the same cycle, evt_ready=1 -> 4 consecutive valid cycles, evt_ch 0,1,2,3. Then ptr=0; a further toggle on ch 3 and ch 0 yields 0 then 3.
- evt_ready=0; toggle ch1 9 times, spaced 2 cycles -> pend[1]=1, cnt saturates at 7 with the presented event held in the slot. Release ready -> exactly 8 events on ch1 (7+1 in slot). With PULSE_SYNC_OVF_EN, ovf[1]=1 until ovf_clr[1] is pulsed.
- evt_ready toggled randomly at 50% on every cycle, 100 random toggles on 4 channels -> per-channel accepted event count equals toggle count; evt_ch/evt_valid never change while stalled.
- Assert rst for 1 cycle with 3 events pending on ch0 -> evt_valid=0 in the same cycle (async), no ch0 events after release.
